// File: rtl/audio_voice_arbiter.sv
// rtl/audio_voice_arbiter.sv - fixed-priority voice arbiter feeding stereo channel sinks
// Optional macro AUDIO_ARB_SILENCE_EN: emit zero sample pairs while no voice is granted.
module audio_voice_arbiter #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 16,
  parameter int SEL_W      = 2
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [NUM_VOICES*DATA_W-1:0] voice_data,
  input  logic [NUM_VOICES-1:0]        voice_valid,
  input  logic [NUM_VOICES-1:0]        voice_last,
  output logic [NUM_VOICES-1:0]        voice_ready,
  input  logic [2:0]                   volume_shift,
  output logic [DATA_W-1:0]            left_data,
  output logic                         left_valid,
  input  logic                         left_ready,
  output logic [DATA_W-1:0]            right_data,
  output logic                         right_valid,
  input  logic                         right_ready,
  output logic [SEL_W-1:0]             active_voice,
  output logic                         busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [SEL_W-1:0]    r_grant;
  logic                r_busy;
  logic [DATA_W-1:0]   r_sample;
  logic                r_last;
  logic                r_lv;
  logic                r_rv;

  logic                w_any_valid;
  logic [SEL_W-1:0]    w_pick;
  logic                w_gvalid;
  logic                w_glast;
  logic [DATA_W-1:0]   w_gdata;
  logic [DATA_W-1:0]   w_shifted;
  logic                w_pair_done;

  // Descending scan so the lowest-index requester wins.
  always_comb begin
    w_any_valid = |voice_valid;
    w_pick      = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_valid[i]) w_pick = SEL_W'(i);
    end
  end

  always_comb begin
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (r_grant == SEL_W'(i)) begin
        w_gvalid = voice_valid[i];
        w_glast  = voice_last[i];
        w_gdata  = voice_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_shifted   = $signed(w_gdata) >>> volume_shift;
  // A channel is done once its valid has dropped or is being accepted this cycle.
  assign w_pair_done = (!r_lv || left_ready) && (!r_rv || right_ready);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) w_next = ST_LOAD;
`ifdef AUDIO_ARB_SILENCE_EN
        else             w_next = ST_SEND;
`endif
      end
      ST_LOAD: if (w_gvalid) w_next = ST_SEND;
      ST_SEND: if (w_pair_done) w_next = r_last ? ST_IDLE : ST_LOAD;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    voice_ready = '0;
    if (r_state == ST_LOAD) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_ready[i] = (r_grant == SEL_W'(i));
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_sample <= '0;
      r_last   <= 1'b0;
      r_lv     <= 1'b0;
      r_rv     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_valid) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
          end
`ifdef AUDIO_ARB_SILENCE_EN
          else begin
            r_sample <= '0;
            r_last   <= 1'b1;
            r_lv     <= 1'b1;
            r_rv     <= 1'b1;
          end
`endif
        end
        ST_LOAD: begin
          if (w_gvalid) begin
            r_sample <= w_shifted;
            r_last   <= w_glast;
            r_lv     <= 1'b1;
            r_rv     <= 1'b1;
          end
        end
        ST_SEND: begin
          if (r_lv && left_ready)   r_lv <= 1'b0;
          if (r_rv && right_ready)  r_rv <= 1'b0;
          if (w_pair_done && r_last) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign left_data    = r_sample;
  assign right_data   = r_sample;
  assign left_valid   = r_lv;
  assign right_valid  = r_rv;
  assign active_voice = r_grant;
  assign busy         = r_busy;

endmodule

// File: tb/tb_audio_voice_arbiter.sv
// tb/tb_audio_voice_arbiter.sv - directed self-checking bench for audio_voice_arbiter
module tb_audio_voice_arbiter;
  localparam int NV = 4;
  localparam int DW = 16;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NV*DW-1:0] voice_data;
  logic [NV-1:0]  voice_valid;
  logic [NV-1:0]  voice_last;
  logic [NV-1:0]  voice_ready;
  logic [2:0]     volume_shift;
  logic [DW-1:0]  left_data;
  logic           left_valid;
  logic           left_ready;
  logic [DW-1:0]  right_data;
  logic           right_valid;
  logic           right_ready;
  logic [SW-1:0]  active_voice;
  logic           busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int silence_cnt  = 0;

  always #5 clk = ~clk;

  audio_voice_arbiter #(.NUM_VOICES(NV), .DATA_W(DW), .SEL_W(SW)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .voice_data    (voice_data),
    .voice_valid   (voice_valid),
    .voice_last    (voice_last),
    .voice_ready   (voice_ready),
    .volume_shift  (volume_shift),
    .left_data     (left_data),
    .left_valid    (left_valid),
    .left_ready    (left_ready),
    .right_data    (right_data),
    .right_valid   (right_valid),
    .right_ready   (right_ready),
    .active_voice  (active_voice),
    .busy          (busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_lv"}, 32'(left_valid), 32'd0);
    chk({tag, "_rv"}, 32'(right_valid), 32'd0);
    chk({tag, "_ld"}, 32'(left_data), 32'd0);
    chk({tag, "_rd"}, 32'(right_data), 32'd0);
    chk({tag, "_av"}, 32'(active_voice), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(voice_ready), 32'd0);
  endtask

  // Single-sample sound on voice v, starting from IDLE at a falling edge.
  task automatic send_one(input int v, input logic [15:0] d, input logic [2:0] sh,
                          input logic [15:0] exp);
    voice_data[v*DW +: DW] = d;
    voice_valid = '0;
    voice_valid[v] = 1'b1;
    voice_last = '0;
    voice_last[v] = 1'b1;
    volume_shift = sh;
    tick();
    chk("one_av", 32'(active_voice), 32'(v));
    chk("one_rdy", 32'(voice_ready), 32'(1 << v));
    chk("one_busy", 32'(busy), 32'd1);
    chk("one_lv0", 32'(left_valid), 32'd0);
    tick();
    chk("one_lv", 32'(left_valid), 32'd1);
    chk("one_rv", 32'(right_valid), 32'd1);
    chk("one_ld", 32'(left_data), 32'(exp));
    chk("one_rd", 32'(right_data), 32'(exp));
    chk("one_rdy_send", 32'(voice_ready), 32'd0);
    voice_valid = '0;
    voice_last = '0;
    tick();
    chk("one_end_lv", 32'(left_valid), 32'd0);
    chk("one_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    voice_data = '0;
    voice_valid = '0;
    voice_last = '0;
    volume_shift = 3'd0;
    left_ready = 1'b1;
    right_ready = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    send_one(0, 16'h8000, 3'd1, 16'hC000);
    send_one(0, 16'h7FFF, 3'd7, 16'h00FF);
    send_one(3, 16'hFFFF, 3'd5, 16'hFFFF);
    send_one(1, 16'h9000, 3'd4, 16'hF900);

    // Priority: voices 1 and 2 together; voice 1 plays three samples first.
    voice_data[1*DW +: DW] = 16'h0100;
    voice_data[2*DW +: DW] = 16'h0200;
    voice_last = 4'b0100;
    volume_shift = 3'd0;
    voice_valid = 4'b0110;
    tick();
    chk("prio_av", 32'(active_voice), 32'd1);
    for (int s = 0; s < 3; s++) begin
      chk("prio_rdy_load", 32'(voice_ready), 32'b0010);
      if (s == 2) voice_last[1] = 1'b1;
      tick();
      chk("prio_ld", 32'(left_data), 32'(16'h0100 + s));
      chk("prio_rd", 32'(right_data), 32'(16'h0100 + s));
      chk("prio_av_hold", 32'(active_voice), 32'd1);
      chk("prio_rdy_send", 32'(voice_ready), 32'd0);
      voice_data[1*DW +: DW] = 16'h0101 + 16'(s);
      if (s == 2) voice_valid = 4'b0100;
      tick();
    end
    chk("prio_gap_busy", 32'(busy), 32'd0);
    chk("prio_gap_rdy", 32'(voice_ready), 32'd0);
    chk("prio_gap_lv", 32'(left_valid), 32'd0);
    tick();
    chk("prio2_av", 32'(active_voice), 32'd2);
    chk("prio2_busy", 32'(busy), 32'd1);
    chk("prio2_rdy", 32'(voice_ready), 32'b0100);
    tick();
    chk("prio2_ld", 32'(left_data), 32'h0200);
    voice_valid = '0;
    voice_last = '0;
    tick();
    chk("prio2_end_busy", 32'(busy), 32'd0);

    // Right channel back-pressure, then a stalled LOAD.
    voice_data[0 +: DW] = 16'h1234;
    voice_valid = 4'b0001;
    voice_last = '0;
    left_ready = 1'b1;
    right_ready = 1'b0;
    tick();
    chk("bp_rdy_load", 32'(voice_ready), 32'b0001);
    tick();
    voice_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      chk("bp_rv", 32'(right_valid), 32'd1);
      chk("bp_lv", 32'(left_valid), (k == 1) ? 32'd1 : 32'd0);
      chk("bp_rd", 32'(right_data), 32'h1234);
      chk("bp_ld", 32'(left_data), 32'h1234);
      chk("bp_rdy", 32'(voice_ready), 32'd0);
      if (k == 6) right_ready = 1'b1;
      tick();
    end
    chk("bp_after_rv", 32'(right_valid), 32'd0);
    chk("bp_after_rdy", 32'(voice_ready), 32'b0001);
    for (int k = 0; k < 10; k++) begin
      chk("stall_rdy", 32'(voice_ready), 32'b0001);
      chk("stall_lv", 32'(left_valid), 32'd0);
      chk("stall_rv", 32'(right_valid), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    voice_data[0 +: DW] = 16'h0010;
    voice_last = 4'b0001;
    voice_valid = 4'b0001;
    tick();
    chk("resume_lv", 32'(left_valid), 32'd1);
    chk("resume_ld", 32'(left_data), 32'h0010);
    voice_valid = '0;
    voice_last = '0;
    tick();
    chk("resume_end_busy", 32'(busy), 32'd0);

    // No requesters: silence pairs only when the optional feature is built in.
    for (int k = 0; k < 6; k++) begin
      chk("idle_busy", 32'(busy), 32'd0);
`ifdef AUDIO_ARB_SILENCE_EN
      if (left_valid) begin
        silence_cnt++;
        chk("sil_ld", 32'(left_data), 32'd0);
        chk("sil_rv", 32'(right_valid), 32'd1);
      end
`else
      chk("idle_lv", 32'(left_valid), 32'd0);
      chk("idle_rv", 32'(right_valid), 32'd0);
`endif
      tick();
    end
`ifdef AUDIO_ARB_SILENCE_EN
    chk("sil_count", 32'(silence_cnt >= 2), 32'd1);
`endif

    // Reset in the middle of SEND.
    voice_data[0 +: DW] = 16'h4444;
    voice_last = 4'b0001;
    left_ready = 1'b0;
    right_ready = 1'b0;
`ifdef AUDIO_ARB_SILENCE_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif
    voice_valid = 4'b0001;
    tick();
    tick();
    chk("rst_pre_lv", 32'(left_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_mid");
    voice_valid = '0;
    tick();
    chk_quiet("rst_hold");
    rst_n = 1'b1;
    left_ready = 1'b1;
    right_ready = 1'b1;
    voice_data[2*DW +: DW] = 16'h2222;
    voice_last = 4'b0100;
    voice_valid = 4'b0100;
    tick();
    chk("rst_regrant_av", 32'(active_voice), 32'd2);
    chk("rst_regrant_busy", 32'(busy), 32'd1);
    chk("rst_regrant_rdy", 32'(voice_ready), 32'b0100);
    tick();
    chk("rst_regrant_ld", 32'(left_data), 32'h2222);
    voice_valid = '0;
    voice_last = '0;
    tick();
    chk("rst_regrant_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/audio_voice_arbiter.md
Name: audio_voice_arbiter

Overview:
- Shares the stereo audio output core among NUM_VOICES sound-effect requesters.
- Each requester presents a mono 16-bit signed sample stream (valid/ready/last).
- A fixed-priority arbiter grants one voice per sound; the block attenuates each sample and pushes it as an aligned pair into the core's left and right channel sinks.
- Sits between the game/sound logic and the audio core's Avalon-ST channel sinks.

Parameters:
- NUM_VOICES, 4, number of requesters; 2..8.
- DATA_W, 16, sample width; matches the core's channel sink data width.
- SEL_W, 2, width of active_voice; must satisfy 2^SEL_W >= NUM_VOICES.

Ports:
- clk_clk  input  1  system clock; all logic on rising edge.
- reset_reset_n  input  1  reset, asynchronous assert, active-low.
- voice_data  input  NUM_VOICES*DATA_W  voice i sample in bits [i*DATA_W +: DATA_W]; two's complement.
- voice_valid  input  NUM_VOICES  per-voice sample valid.
- voice_last  input  NUM_VOICES  per-voice marker: the current sample is the final sample of the sound.
- voice_ready  output  NUM_VOICES  per-voice sample accept.
- volume_shift  input  3  attenuation as an arithmetic right shift, 0..7.
- left_data  output  DATA_W  to the core's left channel sink.
- left_valid  output  1  left channel sink valid.
- left_ready  input  1  left channel sink ready.
- right_data  output  DATA_W  to the core's right channel sink.
- right_valid  output  1  right channel sink valid.
- right_ready  input  1  right channel sink ready.
- active_voice  output  SEL_W  index of the granted voice.
- busy  output  1  high while a voice is granted.

Behaviour:
- Reset (reset_reset_n low, any time, including mid-sound):
  - State goes to IDLE; grant is cleared.
  - voice_ready=0, left_valid=0, right_valid=0, left_data=0, right_data=0, active_voice=0, busy=0.
  - Any pending sample is dropped.
- FSM states: IDLE, LOAD, SEND.
- IDLE:
  - If any voice_valid is set, grant the lowest-index valid voice.
  - Register that index in active_voice, set busy=1, go to LOAD next cycle.
- LOAD:
  - voice_ready[g]=1 (combinational from state and grant); all other voice_ready bits are 0.
  - On voice_valid[g]:
    - Capture the sample as (signed voice_data[g]) >>> volume_shift, sign-extended.
    - volume_shift is sampled in the same cycle.
    - Latch voice_last[g]; go to SEND.
  - If voice_valid[g] stays low, remain in LOAD indefinitely. There is no timeout and no re-arbitration.
- SEND:
  - left_data and right_data both carry the captured sample.
  - left_valid and right_valid are both 1 on entry.
  - Each valid clears independently in the cycle after its ready is seen high. Ready may arrive in the same cycle for both channels, or in any order.
  - Data is held stable until both channels have accepted.
  - When both have accepted:
    - If last was latched, return to IDLE with busy=0.
    - Otherwise return to LOAD with the same grant.
- Latency: a sample accepted on voice_ready in cycle N drives left_valid and right_valid in cycle N+1.
- Throughput: at best one sample pair every 2 cycles.
- No preemption: a higher-priority voice waits until the granted voice's last sample has been accepted by both channels.
- Re-arbitration occurs only in IDLE. The cycle after a sound ends is IDLE, so back-to-back sounds have a 1-cycle gap.
- Arithmetic: examples 0x8000 >>> 1 = 0xC000; 0x7FFF >>> 7 = 0x00FF; -1 >>> k = 0xFFFF.

Optional Feature:
- Macro: AUDIO_ARB_SILENCE_EN.
- Defined:
  - In IDLE with no voice_valid set, the block enters SEND carrying a zero sample, with last treated as 1.
  - busy stays 0 and active_voice is unchanged.
  - This keeps the core's sinks fed during silence.
  - A voice request arriving during a silence pair is granted only after that pair completes.
- Not defined: left_valid and right_valid stay 0 whenever no voice is granted.

Test Plan:
- Reset mid-SEND with left_valid=1 -> next edge all outputs 0 and state IDLE; after release, voice 2 request is granted fresh with active_voice=2.
- voice_valid=4'b0110 in the same cycle -> active_voice=1; voice 2 is starved until voice 1 completes a 3-sample sound (last on sample 3); then, after one IDLE cycle, active_voice=2.
- Voice 0 sample 0x8000 with volume_shift=1 -> left_data=right_data=0xC000 in the cycle after accept; with shift 7 and 0x7FFF -> 0x00FF.
- left_ready high immediately, right_ready held low 5 cycles -> left_valid drops after 1 cycle, right_valid stays high 6 cycles, data stable; voice_ready stays 0 until right accepts.
- Granted voice deasserts valid for 10 cycles in LOAD -> no sink valid, voice_ready[g] held 1, busy=1; resumes correctly when valid returns.
- With AUDIO_ARB_SILENCE_EN and all voice_valid=0 -> continuous zero pairs, busy=0; without the macro, left_valid=right_valid=0 throughout.
